// File: rtl/pc_branch_ctrl_if.sv
// ============================================================================
// pc_branch_ctrl_if : flag, branch-handshake and PC bus of pc_branch_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

interface pc_branch_ctrl_if #(
    parameter int unsigned PC_WIDTH  = 32,
    parameter int unsigned CNT_WIDTH = 16
);
    logic                 PC_EN;
    logic                 FLAG_WE;
    logic                 NF_IN;
    logic                 ZF_IN;
    logic                 BR_VALID;
    logic                 BR_READY;
    logic [2:0]           BR_COND;
    logic [PC_WIDTH-1:0]  BR_TARGET;
    logic [PC_WIDTH-1:0]  PC;
    logic                 PC_LOAD;
    logic                 BR_TAKEN;
    logic [CNT_WIDTH-1:0] TAKEN_CNT;
    logic [CNT_WIDTH-1:0] NTAKEN_CNT;

    modport master (
        output PC_EN, FLAG_WE, NF_IN, ZF_IN, BR_VALID, BR_COND, BR_TARGET,
        input  BR_READY, PC, PC_LOAD, BR_TAKEN, TAKEN_CNT, NTAKEN_CNT
    );

    modport slave (
        input  PC_EN, FLAG_WE, NF_IN, ZF_IN, BR_VALID, BR_COND, BR_TARGET,
        output BR_READY, PC, PC_LOAD, BR_TAKEN, TAKEN_CNT, NTAKEN_CNT
    );
endinterface

`default_nettype wire

// File: rtl/pc_branch_ctrl.sv
// ============================================================================
// pc_branch_ctrl : PC register, ALU flag latch and branch resolution unit.
// Optional taken/not-taken counters enabled by macro BRANCH_STATS_EN.
// Rev 1.0
// ============================================================================
`default_nettype none

module pc_branch_ctrl #(
    parameter int unsigned          PC_WIDTH  = 32,
    parameter int unsigned          PC_INC    = 4,
    parameter logic [PC_WIDTH-1:0]  RESET_PC  = '0,
    parameter int unsigned          CNT_WIDTH = 16
) (
    input  wire logic          CLK,
    input  wire logic          RST,
    pc_branch_ctrl_if.slave    bus
);

    localparam logic [2:0] c_NEVER  = 3'b000;
    localparam logic [2:0] c_BEQ    = 3'b001;
    localparam logic [2:0] c_BNE    = 3'b010;
    localparam logic [2:0] c_BLTZ   = 3'b011;
    localparam logic [2:0] c_BGEZ   = 3'b100;
    localparam logic [2:0] c_BGTZ   = 3'b101;
    localparam logic [2:0] c_BLEZ   = 3'b110;
    localparam logic [2:0] c_ALWAYS = 3'b111;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t              r_state;
    logic                r_br_ready;
    logic                r_nf;
    logic                r_zf;
    logic                r_flags_vld;
    logic [2:0]          r_cond;
    logic [PC_WIDTH-1:0] r_target;
    logic [PC_WIDTH-1:0] r_pc;
    logic                r_pc_load;
    logic                r_br_taken;

    logic                w_eff_n;
    logic                w_eff_z;
    logic                w_in_wait;
    logic [2:0]          w_sel_cond;
    logic [PC_WIDTH-1:0] w_sel_tgt;
    logic                w_flag_free;
    logic                w_can_resolve;
    logic                w_resolve;
    logic                w_capture;
    logic                w_cond_true;
    logic                w_taken;
    logic                w_consume;

    // Flags written this cycle bypass the latch so a same-cycle branch sees them
    assign w_eff_n       = bus.FLAG_WE ? bus.NF_IN : r_nf;
    assign w_eff_z       = bus.FLAG_WE ? bus.ZF_IN : r_zf;
    assign w_in_wait     = (r_state == S_WAIT);
    assign w_sel_cond    = w_in_wait ? r_cond   : bus.BR_COND;
    assign w_sel_tgt     = w_in_wait ? r_target : bus.BR_TARGET;
    assign w_flag_free   = (bus.BR_COND == c_NEVER) || (bus.BR_COND == c_ALWAYS);
    assign w_can_resolve = w_flag_free || r_flags_vld || bus.FLAG_WE;
    assign w_resolve     = w_in_wait ? bus.FLAG_WE : (bus.BR_VALID && w_can_resolve);
    assign w_capture     = !w_in_wait && bus.BR_VALID && !w_can_resolve;

    always_comb begin
        w_cond_true = 1'b0;
        case (w_sel_cond)
            c_NEVER:  w_cond_true = 1'b0;
            c_BEQ:    w_cond_true = w_eff_z;
            c_BNE:    w_cond_true = !w_eff_z;
            c_BLTZ:   w_cond_true = w_eff_n;
            c_BGEZ:   w_cond_true = !w_eff_n;
            c_BGTZ:   w_cond_true = !w_eff_n && !w_eff_z;
            c_BLEZ:   w_cond_true = w_eff_n || w_eff_z;
            c_ALWAYS: w_cond_true = 1'b1;
            default:  w_cond_true = 1'b0;
        endcase
    end

    assign w_taken   = w_resolve && w_cond_true;
    assign w_consume = w_resolve && (w_sel_cond != c_NEVER) && (w_sel_cond != c_ALWAYS);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_br_ready  <= 1'b1;
            r_nf        <= 1'b0;
            r_zf        <= 1'b0;
            r_flags_vld <= 1'b0;
            r_cond      <= c_NEVER;
            r_target    <= '0;
            r_pc        <= RESET_PC;
            r_pc_load   <= 1'b0;
            r_br_taken  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_state    <= S_WAIT;
                        r_br_ready <= 1'b0;
                        r_cond     <= bus.BR_COND;
                        r_target   <= bus.BR_TARGET;
                    end
                end
                S_WAIT: begin
                    if (bus.FLAG_WE) begin
                        r_state    <= S_IDLE;
                        r_br_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_br_ready <= 1'b1;
                end
            endcase

            if (bus.FLAG_WE) begin
                r_nf <= bus.NF_IN;
                r_zf <= bus.ZF_IN;
            end
            // Consumption overrides a same-cycle flag write
            if (w_consume) begin
                r_flags_vld <= 1'b0;
            end else if (bus.FLAG_WE) begin
                r_flags_vld <= 1'b1;
            end

            if (w_taken) begin
                r_pc       <= w_sel_tgt;
                r_pc_load  <= 1'b1;
                r_br_taken <= 1'b1;
            end else if (bus.PC_EN) begin
                r_pc       <= r_pc + PC_WIDTH'(PC_INC);
                r_pc_load  <= 1'b1;
                r_br_taken <= 1'b0;
            end else begin
                r_pc_load  <= 1'b0;
                r_br_taken <= 1'b0;
            end
        end
    end

    assign bus.BR_READY = r_br_ready;
    assign bus.PC       = r_pc;
    assign bus.PC_LOAD  = r_pc_load;
    assign bus.BR_TAKEN = r_br_taken;

`ifdef BRANCH_STATS_EN
    logic [CNT_WIDTH-1:0] r_taken_cnt;
    logic [CNT_WIDTH-1:0] r_ntaken_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_taken_cnt  <= '0;
            r_ntaken_cnt <= '0;
        end else begin
            if (w_taken && (r_taken_cnt != '1)) begin
                r_taken_cnt <= r_taken_cnt + 1'b1;
            end
            if (w_resolve && !w_taken && (r_ntaken_cnt != '1)) begin
                r_ntaken_cnt <= r_ntaken_cnt + 1'b1;
            end
        end
    end

    assign bus.TAKEN_CNT  = r_taken_cnt;
    assign bus.NTAKEN_CNT = r_ntaken_cnt;
`else
    assign bus.TAKEN_CNT  = '0;
    assign bus.NTAKEN_CNT = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pc_branch_ctrl.sv
// ============================================================================
// tb_pc_branch_ctrl : directed plus random bench for pc_branch_ctrl against a
// behavioural model; a 32-bit and an 8-bit/2-bit-counter instance run in step.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_pc_branch_ctrl;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    pc_branch_ctrl_if #(.PC_WIDTH(32), .CNT_WIDTH(16)) bus_a ();
    pc_branch_ctrl_if #(.PC_WIDTH(8),  .CNT_WIDTH(2))  bus_b ();

    pc_branch_ctrl #(.PC_WIDTH(32), .PC_INC(4), .RESET_PC(32'h0), .CNT_WIDTH(16)) dut_a (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_a)
    );

    pc_branch_ctrl #(.PC_WIDTH(8), .PC_INC(4), .RESET_PC(8'h10), .CNT_WIDTH(2)) dut_b (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_b)
    );

    typedef struct {
        longint unsigned pc;
        bit              load;
        bit              tk;
        bit              pend;
        bit [2:0]        pcond;
        longint unsigned ptgt;
        bit              fvld;
        bit              fn;
        bit              fz;
        longint unsigned tc;
        longint unsigned nc;
    } mdl_t;

    typedef struct {
        bit              rst;
        bit              pc_en;
        bit              fwe;
        bit              n;
        bit              z;
        bit              bv;
        bit [2:0]        cond;
        longint unsigned tgt;
    } stim_t;

    mdl_t ma;
    mdl_t mb;
    int   n_tests = 0;
    int   n_fail  = 0;

    // One clock edge of the architectural behaviour, straight from the rules
    function automatic mdl_t step(mdl_t s, stim_t st, longint unsigned mask,
                                  longint unsigned cmax, longint unsigned rstpc);
        mdl_t            r;
        bit              en, ez, res, flag_free;
        bit [2:0]        cond;
        longint unsigned tgt;
        bit [7:0]        truth;
        r = s;
        r.load = 0;
        r.tk   = 0;
        if (st.rst) begin
            r    = '{default: 0};
            r.pc = rstpc;
            return r;
        end
        en = st.fwe ? st.n : s.fn;
        ez = st.fwe ? st.z : s.fz;
        if (s.pend) begin
            res  = st.fwe;
            cond = s.pcond;
            tgt  = s.ptgt;
            if (st.fwe) r.pend = 0;
        end else begin
            cond      = st.cond;
            tgt       = st.tgt & mask;
            flag_free = (cond == 3'd0) || (cond == 3'd7);
            res       = st.bv && (flag_free || s.fvld || st.fwe);
            if (st.bv && !res) begin
                r.pend  = 1;
                r.pcond = cond;
                r.ptgt  = tgt;
            end
        end
        if (st.fwe) begin
            r.fvld = 1;
            r.fn   = st.n;
            r.fz   = st.z;
        end
        if (res && cond != 3'd0 && cond != 3'd7) r.fvld = 0;
        truth = {1'b1, en || ez, !en && !ez, !en, en, !ez, ez, 1'b0};
        if (res && truth[cond]) begin
            r.pc   = tgt;
            r.load = 1;
            r.tk   = 1;
            if (s.tc < cmax) r.tc = s.tc + 1;
        end else begin
            if (res && s.nc < cmax) r.nc = s.nc + 1;
            if (st.pc_en) begin
                r.pc   = (s.pc + 4) & mask;
                r.load = 1;
            end
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic longint unsigned cnt_exp(longint unsigned v);
`ifdef BRANCH_STATS_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    task automatic cyc(input bit rst, input bit pc_en, input bit fwe, input bit n,
                       input bit z, input bit bv, input bit [2:0] cond,
                       input logic [31:0] tgt);
        stim_t st;
        st = '{rst: rst, pc_en: pc_en, fwe: fwe, n: n, z: z, bv: bv, cond: cond, tgt: tgt};
        RST             = rst;
        bus_a.PC_EN     = pc_en;  bus_b.PC_EN     = pc_en;
        bus_a.FLAG_WE   = fwe;    bus_b.FLAG_WE   = fwe;
        bus_a.NF_IN     = n;      bus_b.NF_IN     = n;
        bus_a.ZF_IN     = z;      bus_b.ZF_IN     = z;
        bus_a.BR_VALID  = bv;     bus_b.BR_VALID  = bv;
        bus_a.BR_COND   = cond;   bus_b.BR_COND   = cond;
        bus_a.BR_TARGET = tgt;    bus_b.BR_TARGET = tgt[7:0];
        @(posedge CLK);
        ma = step(ma, st, 64'hFFFF_FFFF, 64'hFFFF, 64'h0);
        mb = step(mb, st, 64'hFF, 64'h3, 64'h10);
        #1;
        check("a_pc",     64'(bus_a.PC),         ma.pc);
        check("a_load",   64'(bus_a.PC_LOAD),    64'(ma.load));
        check("a_taken",  64'(bus_a.BR_TAKEN),   64'(ma.tk));
        check("a_ready",  64'(bus_a.BR_READY),   64'(!ma.pend));
        check("a_tcnt",   64'(bus_a.TAKEN_CNT),  cnt_exp(ma.tc));
        check("a_ncnt",   64'(bus_a.NTAKEN_CNT), cnt_exp(ma.nc));
        check("b_pc",     64'(bus_b.PC),         mb.pc);
        check("b_load",   64'(bus_b.PC_LOAD),    64'(mb.load));
        check("b_taken",  64'(bus_b.BR_TAKEN),   64'(mb.tk));
        check("b_ready",  64'(bus_b.BR_READY),   64'(!mb.pend));
        check("b_tcnt",   64'(bus_b.TAKEN_CNT),  cnt_exp(mb.tc));
        check("b_ncnt",   64'(bus_b.NTAKEN_CNT), cnt_exp(mb.nc));
    endtask

    initial begin
        ma = '{default: 0};
        mb = '{default: 0};

        // Reset
        cyc(1, 0, 0, 0, 0, 0, 3'd0, 32'h0);
        cyc(1, 0, 0, 0, 0, 0, 3'd0, 32'h0);
        check("rst_pc_a",    64'(bus_a.PC), 64'h0);
        check("rst_pc_b",    64'(bus_b.PC), 64'h10);
        check("rst_ready_a", 64'(bus_a.BR_READY), 64'h1);
        check("rst_load_a",  64'(bus_a.PC_LOAD), 64'h0);

        // Sequential fetch
        cyc(0, 1, 0, 0, 0, 0, 3'd0, 32'h0);
        check("seq_pc4", 64'(bus_a.PC), 64'h4);
        cyc(0, 1, 0, 0, 0, 0, 3'd0, 32'h0);
        cyc(0, 1, 0, 0, 0, 0, 3'd0, 32'h0);
        check("seq_pc12", 64'(bus_a.PC), 64'hC);

        // Flags first, then BEQ
        cyc(0, 0, 1, 0, 1, 0, 3'd0, 32'h0);
        cyc(0, 0, 0, 0, 0, 1, 3'd1, 32'h100);
        check("beq_pc",    64'(bus_a.PC), 64'h100);
        check("beq_taken", 64'(bus_a.BR_TAKEN), 64'h1);

        // BGTZ without flags waits, then resolves on the flag write
        cyc(0, 0, 0, 0, 0, 1, 3'd5, 32'h200);
        check("bgtz_wait", 64'(bus_a.BR_READY), 64'h0);
        cyc(0, 0, 0, 0, 0, 1, 3'd7, 32'h300);
        cyc(0, 0, 0, 0, 0, 0, 3'd0, 32'h0);
        cyc(0, 0, 1, 0, 0, 0, 3'd0, 32'h0);
        check("bgtz_pc",    64'(bus_a.PC), 64'h200);
        check("bgtz_ready", 64'(bus_a.BR_READY), 64'h1);

        // BLEZ not taken with PC_EN in the same cycle
        cyc(0, 1, 1, 0, 0, 1, 3'd6, 32'h400);
        check("blez_pc", 64'(bus_a.PC), 64'h204);

        // Wrap on the 8-bit instance
        cyc(0, 0, 0, 0, 0, 1, 3'd7, 32'hFC);
        cyc(0, 1, 0, 0, 0, 0, 3'd0, 32'h0);
        check("wrap_pc_b", 64'(bus_b.PC), 64'h0);

        // Reset while waiting discards the branch
        cyc(0, 0, 0, 0, 0, 1, 3'd1, 32'h80);
        cyc(1, 0, 0, 0, 0, 0, 3'd0, 32'h0);
        check("rstw_pc_b",    64'(bus_b.PC), 64'h10);
        check("rstw_ready_b", 64'(bus_b.BR_READY), 64'h1);
        cyc(0, 0, 1, 0, 1, 0, 3'd0, 32'h0);
        check("rstw_notaken", 64'(bus_b.BR_TAKEN), 64'h0);

        // Counter saturation on the 2-bit instance
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 0, 1, 3'd7, 32'h40 + 32'(i));

        // Random traffic
        for (int i = 0; i < 500; i++) begin
            cyc($urandom_range(0, 59) == 0, 1'($urandom), 1'($urandom_range(0, 2) == 0),
                1'($urandom), 1'($urandom), 1'($urandom), 3'($urandom), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
